// File: rtl/magia_fsync_node.sv
// -----------------------------------------------------------------------------
// magia_fsync_node
//
// Purpose:
//   One aggregation node of the Fractal Sync barrier tree. The node gathers
//   barrier arrivals from up to N_CHILDREN children for each barrier ID. A
//   barrier aimed at this node's level is closed here, and a local wake is
//   broadcast. A barrier aimed at a higher level is forwarded to the parent,
//   and the parent's wake is later relayed back down. Children that are not
//   populated (CHILD_MASK bit 0) always count as arrived and are never woken.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   child_req_valid_i[c]    arrival from child c
//   child_req_lvl_i[c]      target tree level of that arrival
//   child_req_id_i[c]       barrier ID of that arrival
//   child_req_ready_o[c]    arrival accepted when valid & ready; the only
//                           combinational output (decoded from slot state)
//   child_wake_valid_o      one-cycle wake pulse, equal to CHILD_MASK
//   child_wake_id_o         barrier ID of the wake
//   parent_req_valid_o/lvl_o/id_o, parent_req_ready_i
//                           upward arrival; held stable while stalled
//   parent_wake_valid_i/id_i  single-cycle wake from the parent
//   err_o                   one-cycle pulse. It is raised for a bad level, a
//                           level mismatch, or an unexpected parent wake.
//
// LVL_MAX is the highest level present in the tree. Its default covers the
// whole level field.
// -----------------------------------------------------------------------------
module magia_fsync_node #(
  parameter int unsigned              N_CHILDREN = 2,
  parameter logic [N_CHILDREN-1:0]    CHILD_MASK = {N_CHILDREN{1'b1}},
  parameter int unsigned              LEVEL      = 1,
  parameter int unsigned              LVL_W      = 3,
  parameter int unsigned              LVL_MAX    = (1 << LVL_W) - 1,
  parameter int unsigned              ID_W       = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_CHILDREN-1:0]               child_req_valid_i,
  input  logic [N_CHILDREN-1:0][LVL_W-1:0]    child_req_lvl_i,
  input  logic [N_CHILDREN-1:0][ID_W-1:0]     child_req_id_i,
  output logic [N_CHILDREN-1:0]               child_req_ready_o,
  output logic [N_CHILDREN-1:0]               child_wake_valid_o,
  output logic [ID_W-1:0]                     child_wake_id_o,
  output logic                                parent_req_valid_o,
  output logic [LVL_W-1:0]                    parent_req_lvl_o,
  output logic [ID_W-1:0]                     parent_req_id_o,
  input  logic                                parent_req_ready_i,
  input  logic                                parent_wake_valid_i,
  input  logic [ID_W-1:0]                     parent_wake_id_i,
  output logic                                err_o
);

  localparam int unsigned N_SLOTS = 1 << ID_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_ROOT_WAKE = 3'd2,
    S_FWD_REQ   = 3'd3,
    S_WAIT_WAKE = 3'd4,
    S_DOWN_WAKE = 3'd5
  } slot_state_e;

  // Per-ID slot state
  slot_state_e             state_reg  [N_SLOTS];
  slot_state_e             state_next [N_SLOTS];
  logic [N_CHILDREN-1:0]   bitmap_reg [N_SLOTS];
  logic [N_CHILDREN-1:0]   bitmap_next[N_SLOTS];
  logic [LVL_W-1:0]        lvl_reg    [N_SLOTS];
  logic [LVL_W-1:0]        lvl_next   [N_SLOTS];
  logic [ID_W-1:0]         rr_reg, rr_next;

  // Registered outputs
  logic [N_CHILDREN-1:0]   child_wake_valid_reg, child_wake_valid_next;
  logic [ID_W-1:0]         child_wake_id_reg, child_wake_id_next;
  logic                    parent_req_valid_reg, parent_req_valid_next;
  logic [LVL_W-1:0]        parent_req_lvl_reg, parent_req_lvl_next;
  logic [ID_W-1:0]         parent_req_id_reg, parent_req_id_next;
  logic                    err_reg, err_next;

  // Scratch signals shared between the next-state and output processes
  logic                    parent_hs;
  logic                    parent_load;
  logic [ID_W-1:0]         acc_id;
  logic [LVL_W-1:0]        acc_lvl;
  logic                    down_found, root_found, wake_any;
  logic [ID_W-1:0]         down_id, root_id, wake_sel;
  logic                    fwd_found;
  logic [ID_W-1:0]         fwd_id, scan_id;

  // Ready is decoded only from the addressed slot, never from valid, so a
  // child may hold its request while the slot is busy.
  for (genvar gi = 0; gi < N_CHILDREN; gi++) begin : g_ready
    if (CHILD_MASK[gi]) begin : g_pop
      assign child_req_ready_o[gi] =
          ((state_reg[child_req_id_i[gi]] == S_IDLE) ||
           (state_reg[child_req_id_i[gi]] == S_COLLECT)) &&
          !bitmap_reg[child_req_id_i[gi]][gi];
    end else begin : g_unpop
      assign child_req_ready_o[gi] = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        state_reg[s]  <= S_IDLE;
        bitmap_reg[s] <= '0;
        lvl_reg[s]    <= '0;
      end
      rr_reg               <= '0;
      child_wake_valid_reg <= '0;
      child_wake_id_reg    <= '0;
      parent_req_valid_reg <= 1'b0;
      parent_req_lvl_reg   <= '0;
      parent_req_id_reg    <= '0;
      err_reg              <= 1'b0;
    end else begin
      for (int s = 0; s < N_SLOTS; s++) begin
        state_reg[s]  <= state_next[s];
        bitmap_reg[s] <= bitmap_next[s];
        lvl_reg[s]    <= lvl_next[s];
      end
      rr_reg               <= rr_next;
      child_wake_valid_reg <= child_wake_valid_next;
      child_wake_id_reg    <= child_wake_id_next;
      parent_req_valid_reg <= parent_req_valid_next;
      parent_req_lvl_reg   <= parent_req_lvl_next;
      parent_req_id_reg    <= parent_req_id_next;
      err_reg              <= err_next;
    end
  end

  // Next-state logic. The steps are ordered so that an arrival that completes
  // a barrier, and a parent wake, can both reach the wake and parent
  // arbiters in the same cycle.
  always_comb begin
    for (int s = 0; s < N_SLOTS; s++) begin
      state_next[s]  = state_reg[s];
      bitmap_next[s] = bitmap_reg[s];
      lvl_next[s]    = lvl_reg[s];
    end
    err_next   = 1'b0;
    acc_id     = '0;
    acc_lvl    = '0;
    parent_hs  = parent_req_valid_reg && parent_req_ready_i;
    down_found = 1'b0;
    root_found = 1'b0;
    down_id    = '0;
    root_id    = '0;
    wake_any   = 1'b0;
    wake_sel   = '0;
    fwd_found  = 1'b0;
    fwd_id     = '0;
    scan_id    = '0;

    // Arrivals. Children are processed in index order, so the lowest-indexed
    // valid arrival to an idle slot defines the level of the barrier.
    for (int c = 0; c < N_CHILDREN; c++) begin
      if (child_req_valid_i[c] && child_req_ready_o[c]) begin
        acc_id  = child_req_id_i[c];
        acc_lvl = child_req_lvl_i[c];
        if ((32'(acc_lvl) < LEVEL) || (32'(acc_lvl) > LVL_MAX)) begin
          err_next = 1'b1;  // accepted but dropped
        end else begin
          bitmap_next[acc_id][c] = 1'b1;
          if (state_next[acc_id] == S_IDLE) begin
            state_next[acc_id] = S_COLLECT;
            lvl_next[acc_id]   = acc_lvl;
          end else if (acc_lvl != lvl_next[acc_id]) begin
            err_next = 1'b1;  // counted, but the first level is kept
          end
        end
      end
    end

    // Completion: every populated child has arrived
    for (int s = 0; s < N_SLOTS; s++) begin
      if ((state_next[s] == S_COLLECT) && (&(bitmap_next[s] | ~CHILD_MASK))) begin
        state_next[s] = (32'(lvl_next[s]) == LEVEL) ? S_ROOT_WAKE : S_FWD_REQ;
      end
    end

    // Upward handshake
    rr_next = rr_reg;
    if (parent_hs) begin
      state_next[parent_req_id_reg] = S_WAIT_WAKE;
      rr_next = parent_req_id_reg + 1'b1;
    end

    // A parent wake is legal only for a slot that was already waiting
    if (parent_wake_valid_i) begin
      if (state_reg[parent_wake_id_i] == S_WAIT_WAKE) begin
        state_next[parent_wake_id_i] = S_DOWN_WAKE;
      end else begin
        err_next = 1'b1;
      end
    end

    // Wake arbiter: relayed wakes first, then local ones; lowest ID first
    for (int s = 0; s < N_SLOTS; s++) begin
      if (!down_found && (state_next[s] == S_DOWN_WAKE)) begin
        down_found = 1'b1;
        down_id    = ID_W'(s);
      end
      if (!root_found && (state_next[s] == S_ROOT_WAKE)) begin
        root_found = 1'b1;
        root_id    = ID_W'(s);
      end
    end
    wake_any = down_found || root_found;
    wake_sel = down_found ? down_id : root_id;
    if (wake_any) begin
      state_next[wake_sel]  = S_IDLE;
      bitmap_next[wake_sel] = '0;
    end

    // Parent request arbiter: round-robin scan that starts at the pointer.
    // A slot stays FWD_REQ while it sits in the output register, so a
    // new slot is chosen only when the register is empty or draining.
    parent_load = !parent_req_valid_reg || parent_req_ready_i;
    for (int k = 0; k < N_SLOTS; k++) begin
      scan_id = rr_next + ID_W'(k);
      if (!fwd_found && (state_next[scan_id] == S_FWD_REQ)) begin
        fwd_found = 1'b1;
        fwd_id    = scan_id;
      end
    end
  end

  // Output logic (values loaded into the output registers)
  always_comb begin
    child_wake_valid_next = wake_any ? CHILD_MASK : '0;
    child_wake_id_next    = wake_any ? wake_sel : '0;
    parent_req_valid_next = parent_req_valid_reg;
    parent_req_lvl_next   = parent_req_lvl_reg;
    parent_req_id_next    = parent_req_id_reg;
    if (parent_load) begin
      parent_req_valid_next = fwd_found;
      parent_req_id_next    = fwd_found ? fwd_id : '0;
      parent_req_lvl_next   = fwd_found ? lvl_next[fwd_id] : '0;
    end
  end

  assign child_wake_valid_o = child_wake_valid_reg;
  assign child_wake_id_o    = child_wake_id_reg;
  assign parent_req_valid_o = parent_req_valid_reg;
  assign parent_req_lvl_o   = parent_req_lvl_reg;
  assign parent_req_id_o    = parent_req_id_reg;
  assign err_o              = err_reg;

endmodule

// File: tb/tb_magia_fsync_node.sv
// -----------------------------------------------------------------------------
// tb_magia_fsync_node
//
// Bench for a four-child node with child 3 unpopulated, at level 2, where
// the highest level in the tree is 5. A barrier-level model tracks each
// barrier ID and predicts every output once per cycle. Directed scenarios
// also pin key outputs with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_magia_fsync_node;

  localparam int          NC      = 4;
  localparam logic [3:0]  MASK    = 4'b0111;
  localparam int          LEV     = 2;
  localparam int          LVW     = 3;
  localparam int          LMAX    = 5;
  localparam int          IDW     = 2;

  logic                clk;
  logic                rst;
  logic [3:0]          cv;
  logic [3:0][2:0]     clvl;
  logic [3:0][1:0]     cid;
  logic [3:0]          cready;
  logic [3:0]          wv;
  logic [1:0]          wid;
  logic                pv;
  logic [2:0]          plvl;
  logic [1:0]          pid;
  logic                pready;
  logic                pwv;
  logic [1:0]          pwid;
  logic                err;

  magia_fsync_node #(
    .N_CHILDREN (NC),
    .CHILD_MASK (MASK),
    .LEVEL      (LEV),
    .LVL_W      (LVW),
    .LVL_MAX    (LMAX),
    .ID_W       (IDW)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .child_req_valid_i   (cv),
    .child_req_lvl_i     (clvl),
    .child_req_id_i      (cid),
    .child_req_ready_o   (cready),
    .child_wake_valid_o  (wv),
    .child_wake_id_o     (wid),
    .parent_req_valid_o  (pv),
    .parent_req_lvl_o    (plvl),
    .parent_req_id_o     (pid),
    .parent_req_ready_i  (pready),
    .parent_wake_valid_i (pwv),
    .parent_wake_id_i    (pwid),
    .err_o               (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Barrier model. Each ID is in one of the following phases: free,
  // gathering, locally done, waiting to go up, sent up, or woken from above.
  // ---------------------------------------------------------------------------
  localparam int P_FREE = 0, P_GATHER = 1, P_LOCAL = 2, P_UP = 3, P_SENT = 4, P_DOWN = 5;

  int          ph   [4];
  logic [3:0]  got  [4];
  int          blvl [4];
  int          m_rr;
  logic [3:0]  e_wv;
  int          e_wid, e_pv, e_plvl, e_pid, e_err;

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    int id;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      id = int'(cid[c]);
      if (MASK[c] && (ph[id] == P_FREE || ph[id] == P_GATHER) && !got[id][c]) r[c] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    int         old_ph [4];
    logic [3:0] rdy;
    int         id, l, sel, e;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ph[i] = P_FREE; got[i] = '0; blvl[i] = 0;
      end
      m_rr = 0; e_wv = '0; e_wid = 0; e_pv = 0; e_plvl = 0; e_pid = 0; e_err = 0;
      return;
    end
    old_ph = ph;
    rdy = model_ready();
    e = 0;
    for (int c = 0; c < 4; c++) begin
      if (cv[c] && rdy[c]) begin
        id = int'(cid[c]);
        l  = int'(clvl[c]);
        if (l < LEV || l > LMAX) e = 1;
        else begin
          got[id][c] = 1'b1;
          if (ph[id] == P_FREE) begin
            ph[id] = P_GATHER; blvl[id] = l;
          end else if (l != blvl[id]) e = 1;
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (ph[i] == P_GATHER && ((got[i] | ~MASK) == 4'hF))
        ph[i] = (blvl[i] == LEV) ? P_LOCAL : P_UP;
    if (e_pv != 0 && pready) begin
      ph[e_pid] = P_SENT;
      m_rr = (e_pid + 1) % 4;
    end
    if (pwv) begin
      if (old_ph[int'(pwid)] == P_SENT) ph[int'(pwid)] = P_DOWN;
      else e = 1;
    end
    sel = -1;
    for (int i = 0; i < 4; i++) if (sel < 0 && ph[i] == P_DOWN) sel = i;
    if (sel < 0) for (int i = 0; i < 4; i++) if (sel < 0 && ph[i] == P_LOCAL) sel = i;
    if (sel >= 0) begin
      e_wv = MASK; e_wid = sel; ph[sel] = P_FREE; got[sel] = '0;
    end else begin
      e_wv = '0; e_wid = 0;
    end
    if (e_pv == 0 || pready) begin
      e_pv = 0; e_pid = 0; e_plvl = 0;
      for (int k = 0; k < 4; k++) begin
        id = (m_rr + k) % 4;
        if (e_pv == 0 && ph[id] == P_UP) begin
          e_pv = 1; e_pid = id; e_plvl = blvl[id];
        end
      end
    end
    e_err = e;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_ready", int'(cready), int'(model_ready()));
        check("cyc_wake_valid", int'(wv), int'(e_wv));
        check("cyc_wake_id", int'(wid), e_wid);
        check("cyc_parent_valid", int'(pv), e_pv);
        if (e_pv != 0) begin
          check("cyc_parent_lvl", int'(plvl), e_plvl);
          check("cyc_parent_id", int'(pid), e_pid);
        end
        check("cyc_err", int'(err), e_err);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: each drive lasts exactly one cycle
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    cv  = '0;
    pwv = 1'b0;
  endtask

  task automatic arrive(input int c, input int id, input int l);
    cv[c]   = 1'b1;
    cid[c]  = 2'(id);
    clvl[c] = 3'(l);
    $display("[TB] arrival child=%0d id=%0d lvl=%0d t=%0t", c, id, l, $time);
  endtask

  task automatic pwake(input int id);
    pwv  = 1'b1;
    pwid = 2'(id);
    $display("[TB] parent wake id=%0d t=%0t", id, $time);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    $display("[TB] reset t=%0t", $time);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cv = '0; clvl = '0; cid = '0; pready = 1'b1; pwv = 1'b0; pwid = '0;
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    check("rst_ready", int'(cready), 7);
    check("rst_wake_valid", int'(wv), 0);
    check("rst_parent_valid", int'(pv), 0);
    check("rst_err", int'(err), 0);

    // Local barrier id1 at this level, with arrivals spread over time
    arrive(0, 1, 2); tick();
    tick();
    arrive(1, 1, 2); tick();
    check("t1_no_early_wake", int'(wv), 0);
    tick();
    arrive(2, 1, 2); tick();
    check("t1_wake_valid", int'(wv), 7);
    check("t1_wake_id", int'(wid), 1);
    check("t1_child3_unready", int'(cready[3]), 0);
    tick();
    check("t1_wake_pulse", int'(wv), 0);

    // Forward barrier id0 under parent backpressure
    pready = 1'b0;
    arrive(0, 0, 3); arrive(1, 0, 3); arrive(2, 0, 3); tick();
    check("t2_pv_c2", int'(pv), 1);
    check("t2_plvl_c2", int'(plvl), 3);
    check("t2_pid_c2", int'(pid), 0);
    tick();
    check("t2_pv_c3", int'(pv), 1);
    check("t2_plvl_c3", int'(plvl), 3);
    pready = 1'b1;
    tick();
    check("t2_pv_after_hs", int'(pv), 0);
    tick(); tick(); tick();
    pwake(0); tick();
    check("t2_down_wake_valid", int'(wv), 7);
    check("t2_down_wake_id", int'(wid), 0);
    tick();

    // Round-robin arbitration: id0 and id2 complete together
    do_reset();
    arrive(0, 0, 3); arrive(1, 0, 3); arrive(2, 2, 3); tick();
    arrive(0, 2, 3); tick();
    arrive(2, 0, 3); arrive(1, 2, 3); tick();
    check("t3_first_pid", int'(pid), 0);
    check("t3_first_pv", int'(pv), 1);
    tick();
    check("t3_second_pid", int'(pid), 2);
    check("t3_second_pv", int'(pv), 1);
    tick();
    check("t3_drained", int'(pv), 0);
    pwake(0); tick();
    pwake(2); tick();
    check("t3_wake_id2", int'(wid), 2);
    tick();
    // Pointer now sits at 3: id3 is granted before id0
    arrive(0, 0, 4); arrive(1, 0, 4); arrive(2, 3, 4); tick();
    arrive(0, 3, 4); tick();
    arrive(2, 0, 4); arrive(1, 3, 4); tick();
    check("t3_rr_first", int'(pid), 3);
    check("t3_rr_lvl", int'(plvl), 4);
    tick();
    check("t3_rr_second", int'(pid), 0);
    tick();
    pwake(3); tick();
    pwake(0); tick();
    tick();

    // Duplicate arrival is backpressured until the slot reopens
    do_reset();
    arrive(0, 1, 2); tick();
    cv[0] = 1'b1; #1;
    check("t4_dup_blocked", int'(cready[0]), 0);
    tick();
    cv[0] = 1'b1; arrive(1, 1, 2); arrive(2, 1, 2); tick();
    cv[0] = 1'b1; #1;
    check("t4_reopen_wake", int'(wv), 7);
    check("t4_reopen_ready", int'(cready[0]), 1);
    tick();
    #1;
    check("t4_new_open", int'(cready[0]), 0);
    arrive(1, 1, 2); arrive(2, 1, 2); tick();
    check("t4_second_wake", int'(wid), 1);
    tick();

    // Error sources
    do_reset();
    arrive(0, 3, 1); tick();
    check("t5_lvl_low_err", int'(err), 1);
    #1;
    check("t5_lvl_low_no_state", int'(cready[0]), 1);
    arrive(0, 3, 6); tick();
    check("t5_lvl_high_err", int'(err), 1);
    pwake(3); tick();
    check("t5_idle_wake_err", int'(err), 1);
    check("t5_idle_wake_none", int'(wv), 0);
    tick();
    check("t5_err_pulse", int'(err), 0);
    arrive(0, 2, 2); tick();
    check("t5_open_ok", int'(err), 0);
    arrive(1, 2, 3); tick();
    check("t5_mismatch_err", int'(err), 1);
    arrive(2, 2, 5); tick();
    check("t5_keeps_lvl_root", int'(wv), 7);
    check("t5_keeps_lvl_noparent", int'(pv), 0);
    tick();

    // Reset while a barrier waits for its parent wake
    arrive(0, 0, 3); arrive(1, 0, 3); arrive(2, 0, 3); tick();
    check("t6_fwd", int'(pv), 1);
    tick();
    do_reset();
    check("t6_rst_pv", int'(pv), 0);
    pwake(0); tick();
    check("t6_stale_err", int'(err), 1);
    check("t6_stale_no_wake", int'(wv), 0);
    tick(); tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
